// File: rtl/axi_interface_if.sv
`default_nettype none
// ============================================================================
// axi_interface_if : AXI4 AR/R and AW/W/B channel bundle with slave/master views
// Revision: 1.0
// ============================================================================
interface axi_interface_if #(
  parameter int ID_W   = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64
);
  logic                  arvalid;
  logic                  arready;
  logic [ID_W-1:0]       arid;
  logic [ADDR_W-1:0]     araddr;
  logic [7:0]            arlen;
  logic [2:0]            arsize;
  logic [1:0]            arburst;
  logic                  rvalid;
  logic                  rready;
  logic [DATA_W-1:0]     rdata;
  logic [ID_W-1:0]       rid;
  logic [1:0]            rresp;
  logic                  rlast;

  logic                  awvalid;
  logic                  awready;
  logic [ID_W-1:0]       awid;
  logic [ADDR_W-1:0]     awaddr;
  logic [7:0]            awlen;
  logic [2:0]            awsize;
  logic [1:0]            awburst;
  logic                  wvalid;
  logic                  wready;
  logic [DATA_W-1:0]     wdata;
  logic [DATA_W/8-1:0]   wstrb;
  logic                  wlast;
  logic                  bvalid;
  logic                  bready;
  logic [ID_W-1:0]       bid;
  logic [1:0]            bresp;

  modport rd_slv (
    input  arvalid, arid, araddr, arlen, arsize, arburst, rready,
    output arready, rvalid, rdata, rid, rresp, rlast
  );
  modport rd_mst (
    output arvalid, arid, araddr, arlen, arsize, arburst, rready,
    input  arready, rvalid, rdata, rid, rresp, rlast
  );
  modport wr_slv (
    input  awvalid, awid, awaddr, awlen, awsize, awburst, wvalid, wdata, wstrb, wlast, bready,
    output awready, wready, bvalid, bid, bresp
  );
  modport wr_mst (
    output awvalid, awid, awaddr, awlen, awsize, awburst, wvalid, wdata, wstrb, wlast, bready,
    input  awready, wready, bvalid, bid, bresp
  );
endinterface
`default_nettype wire

// File: rtl/axi_burst_ram_slave.sv
`default_nettype none
// ============================================================================
// axi_burst_ram_slave : AXI4 incrementing-burst RAM, independent read/write FSMs
// Option macro AXI_RAM_BOUNDS_CHECK_EN: out-of-range beats give SLVERR. Rev 1.0
// ============================================================================
module axi_burst_ram_slave #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 32,
  parameter int DEPTH  = 4096,
  parameter int ID_W   = 4
) (
  input wire              clk,
  input wire              rst,
  axi_interface_if.rd_slv axi_read_in,
  axi_interface_if.wr_slv axi_write_in
);
  localparam int NB      = DATA_W / 8;
  localparam int BOFF_W  = $clog2(NB);
  localparam int DEPTH_W = $clog2(DEPTH);
  localparam int IDX_W   = ADDR_W - BOFF_W;
  // Spare top bit: start index plus 255 beats can never overflow the pointer.
  localparam int PTR_W   = IDX_W + 1;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [0:0] RD_IDLE  = 1'b0;
  localparam logic [0:0] RD_BURST = 1'b1;

  localparam logic [1:0] WR_IDLE = 2'd0;
  localparam logic [1:0] WR_DATA = 2'd1;
  localparam logic [1:0] WR_RESP = 2'd2;

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic [0:0]        rd_state_q, rd_state_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  ar_ptr, rd_ld_ptr;
  logic [7:0]        rd_cnt_q, rd_cnt_d;
  logic [7:0]        rd_len_q, rd_len_d;
  logic [ID_W-1:0]   rd_id_q, rd_id_d;
  logic [DATA_W-1:0] rdata_q;
  logic [1:0]        rresp_q;
  logic              ar_hs, r_hs, rd_last, rd_load, rd_ld_oob;

  logic [1:0]        wr_state_q, wr_state_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  aw_ptr, wr_cur_ptr;
  logic [7:0]        wr_cnt_q, wr_cnt_d;
  logic [7:0]        wr_len_q, wr_len_d;
  logic [ID_W-1:0]   wr_id_q, wr_id_d;
  logic              wr_err_q, wr_err_d;
  logic              aw_hs, w_hs, b_hs, wr_cur_oob, mem_we;

  assign ar_ptr = {1'b0, axi_read_in.araddr[ADDR_W-1:BOFF_W]};
  assign aw_ptr = {1'b0, axi_write_in.awaddr[ADDR_W-1:BOFF_W]};

  assign ar_hs = axi_read_in.arvalid && axi_read_in.arready;
  assign r_hs  = axi_read_in.rvalid  && axi_read_in.rready;
  assign aw_hs = axi_write_in.awvalid && axi_write_in.awready;
  assign w_hs  = axi_write_in.wvalid  && axi_write_in.wready;
  assign b_hs  = axi_write_in.bvalid  && axi_write_in.bready;

  assign rd_last    = (rd_state_q == RD_BURST) && (rd_cnt_q == rd_len_q);
  assign rd_ld_ptr  = (rd_state_q == RD_IDLE) ? ar_ptr : rd_ptr_q + PTR_W'(1);
  assign wr_cur_ptr = (wr_state_q == WR_IDLE) ? aw_ptr : wr_ptr_q;

`ifdef AXI_RAM_BOUNDS_CHECK_EN
  assign rd_ld_oob  = |rd_ld_ptr[PTR_W-1:DEPTH_W];
  assign wr_cur_oob = |wr_cur_ptr[PTR_W-1:DEPTH_W];
`else
  assign rd_ld_oob  = 1'b0;
  assign wr_cur_oob = 1'b0;
`endif

  assign mem_we = w_hs && !wr_cur_oob;

  // ---------------------------------------------------------------- read FSM
  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_state_q <= RD_IDLE;
    end else begin
      rd_state_q <= rd_state_d;
    end
  end

  always_comb begin
    rd_state_d = rd_state_q;
    rd_ptr_d   = rd_ptr_q;
    rd_cnt_d   = rd_cnt_q;
    rd_len_d   = rd_len_q;
    rd_id_d    = rd_id_q;
    rd_load    = 1'b0;
    unique case (rd_state_q)
      RD_IDLE: begin
        if (ar_hs) begin
          rd_state_d = RD_BURST;
          rd_ptr_d   = ar_ptr;
          rd_cnt_d   = 8'd0;
          rd_len_d   = axi_read_in.arlen;
          rd_id_d    = axi_read_in.arid;
          rd_load    = 1'b1;
        end
      end
      RD_BURST: begin
        if (r_hs) begin
          if (rd_last) begin
            rd_state_d = RD_IDLE;
          end else begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
            rd_cnt_d = rd_cnt_q + 8'd1;
            rd_load  = 1'b1;
          end
        end
      end
      default: rd_state_d = RD_IDLE;
    endcase
  end

  always_comb begin
    axi_read_in.arready = rst && (rd_state_q == RD_IDLE);
    axi_read_in.rvalid  = (rd_state_q == RD_BURST);
    axi_read_in.rlast   = rd_last;
    axi_read_in.rdata   = rdata_q;
    axi_read_in.rid     = rd_id_q;
    axi_read_in.rresp   = rresp_q;
  end

  // Read data is fetched one step ahead, so a same-cycle write is not seen.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_ptr_q <= '0;
      rd_cnt_q <= 8'd0;
      rd_len_q <= 8'd0;
      rd_id_q  <= '0;
      rdata_q  <= '0;
      rresp_q  <= RESP_OKAY;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      rd_cnt_q <= rd_cnt_d;
      rd_len_q <= rd_len_d;
      rd_id_q  <= rd_id_d;
      if (rd_load) begin
        rdata_q <= rd_ld_oob ? '0 : mem_q[rd_ld_ptr[DEPTH_W-1:0]];
        rresp_q <= rd_ld_oob ? RESP_SLVERR : RESP_OKAY;
      end
    end
  end

  // --------------------------------------------------------------- write FSM
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_state_q <= WR_IDLE;
    end else begin
      wr_state_q <= wr_state_d;
    end
  end

  always_comb begin
    wr_state_d = wr_state_q;
    wr_ptr_d   = wr_ptr_q;
    wr_cnt_d   = wr_cnt_q;
    wr_len_d   = wr_len_q;
    wr_id_d    = wr_id_q;
    wr_err_d   = wr_err_q;
    unique case (wr_state_q)
      WR_IDLE: begin
        if (aw_hs) begin
          wr_len_d = axi_write_in.awlen;
          wr_id_d  = axi_write_in.awid;
          if (w_hs) begin
            wr_err_d = wr_cur_oob;
            if (axi_write_in.awlen == 8'd0) begin
              wr_state_d = WR_RESP;
            end else begin
              wr_state_d = WR_DATA;
              wr_ptr_d   = aw_ptr + PTR_W'(1);
              wr_cnt_d   = 8'd1;
            end
          end else begin
            wr_state_d = WR_DATA;
            wr_err_d   = 1'b0;
            wr_ptr_d   = aw_ptr;
            wr_cnt_d   = 8'd0;
          end
        end
      end
      WR_DATA: begin
        if (w_hs) begin
          wr_err_d = wr_err_q | wr_cur_oob;
          if (wr_cnt_q == wr_len_q) begin
            wr_state_d = WR_RESP;
          end else begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
            wr_cnt_d = wr_cnt_q + 8'd1;
          end
        end
      end
      WR_RESP: begin
        if (b_hs) begin
          wr_state_d = WR_IDLE;
        end
      end
      default: wr_state_d = WR_IDLE;
    endcase
  end

  // Beat 0 may ride along with AW, so wready follows awvalid while idle.
  always_comb begin
    axi_write_in.awready = rst && (wr_state_q == WR_IDLE);
    axi_write_in.wready  = rst && (((wr_state_q == WR_IDLE) && axi_write_in.awvalid) ||
                                   (wr_state_q == WR_DATA));
    axi_write_in.bvalid  = (wr_state_q == WR_RESP);
    axi_write_in.bid     = wr_id_q;
    axi_write_in.bresp   = ((wr_state_q == WR_RESP) && wr_err_q) ? RESP_SLVERR : RESP_OKAY;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      wr_cnt_q <= 8'd0;
      wr_len_q <= 8'd0;
      wr_id_q  <= '0;
      wr_err_q <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      wr_cnt_q <= wr_cnt_d;
      wr_len_q <= wr_len_d;
      wr_id_q  <= wr_id_d;
      wr_err_q <= wr_err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < NB; b++) begin
        if (axi_write_in.wstrb[b]) begin
          mem_q[wr_cur_ptr[DEPTH_W-1:0]][b*8 +: 8] <= axi_write_in.wdata[b*8 +: 8];
        end
      end
    end
  end

  logic unused_sink;
  assign unused_sink = ^{axi_read_in.araddr[BOFF_W-1:0], axi_read_in.arsize,
                         axi_read_in.arburst, axi_write_in.awaddr[BOFF_W-1:0],
                         axi_write_in.awsize, axi_write_in.awburst, axi_write_in.wlast,
                         rd_ld_ptr, wr_cur_ptr};

endmodule
`default_nettype wire
